ret_stack: RTL and testbench

Parametrised LIFO return-address stack for the sequencer's call/return path. It generalises the existing 10-bit × 16 stack with configurable width, depth and return increment. It adds full/empty/count status, sticky overflow/underflow errors, a registered pop-valid strobe and defined simultaneous push/pop behaviour. Callers push a return point and receive it back, plus the increment, on pop.

---
 rtl/ret_stack_pkg.sv | 27 ++
 rtl/ret_stack_mem.sv | 28 ++
 rtl/ret_stack.sv | 151 +++++++++++++++
 tb/tb_ret_stack.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ret_stack_pkg.sv
// Shared helpers for the return-address stack: pointer/count widths and the
// wrapping return-increment add.
package ret_stack_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Add the increment and keep only the low w bits (modulo 2^w).
    function automatic logic [63:0] add_inc(input logic [63:0] v, input logic [63:0] inc, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v + inc) & mask;
    endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module ret_stack_mem
    import ret_stack_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ret_stack.sv
// LIFO return-address stack with status, sticky errors and registered pop.
// Optional macro RET_STACK_WRAP_EN: a push while full overwrites the oldest entry.
module ret_stack
    import ret_stack_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16,
    parameter int INC    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DATA_W-1:0]               push_data,
    input  logic                            clr_err,
    output logic [DATA_W-1:0]               pop_data,
    output logic                            pop_valid,
    output logic [DATA_W-1:0]               top,
    output logic [cnt_width(DEPTH)-1:0]     count,
    output logic                            empty,
    output logic                            full,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  tp_q, tp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              we_s;
    logic [PTR_W-1:0]  waddr_s;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] inc_data_s;
    logic              is_empty_s;
    logic              is_full_s;
    stack_op_e         op_s;

    ret_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (we_s & ~reset),
        .waddr (waddr_s),
        .wdata (push_data),
        .raddr (tp_q),
        .rdata (rdata_s)
    );

    assign is_empty_s = (count_q == {CNT_W{1'b0}});
    assign is_full_s  = (count_q == DEPTH_C);
    assign op_s       = stack_op_e'({push, pop});
    assign inc_data_s = DATA_W'(add_inc(64'(rdata_s), 64'(INC), DATA_W));

    // Next-state decode for pointer, count, pop output and error flags.
    always_comb begin
        tp_d        = tp_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        we_s        = 1'b0;
        waddr_s     = tp_q;
        case (op_s)
            OP_PUSH: begin
                if (!is_full_s) begin
                    tp_d    = tp_q + PTR_W'(1);
                    waddr_s = tp_q + PTR_W'(1);
                    we_s    = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    overflow_d = 1'b1;
`ifdef RET_STACK_WRAP_EN
                    // Overwrite the oldest slot, which is the one just above tp.
                    tp_d    = tp_q + PTR_W'(1);
                    waddr_s = tp_q + PTR_W'(1);
                    we_s    = 1'b1;
`else
                    we_s    = 1'b0;
`endif
                end
            end
            OP_POP: begin
                if (!is_empty_s) begin
                    pop_data_d  = inc_data_s;
                    pop_valid_d = 1'b1;
                    tp_d        = tp_q - PTR_W'(1);
                    count_d     = count_q - CNT_W'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            OP_SWAP: begin
                if (!is_empty_s) begin
                    // Top replaced in place; a full stack cannot overflow here.
                    pop_data_d  = inc_data_s;
                    pop_valid_d = 1'b1;
                    waddr_s     = tp_q;
                    we_s        = 1'b1;
                end else begin
                    underflow_d = 1'b1;
                    tp_d        = tp_q + PTR_W'(1);
                    waddr_s     = tp_q + PTR_W'(1);
                    we_s        = 1'b1;
                    count_d     = CNT_W'(1);
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // State registers; reset overrides every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            tp_q        <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            pop_data_q  <= {DATA_W{1'b0}};
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tp_q        <= tp_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign top       = rdata_s;
    assign count     = count_q;
    assign empty     = is_empty_s;
    assign full      = is_full_s;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ret_stack.sv
// Directed self-checking bench for ret_stack (DATA_W 10, DEPTH 16, INC 1).
module tb_ret_stack;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] push_data;
    logic       clr_err;
    logic [9:0] pop_data;
    logic       pop_valid;
    logic [9:0] top;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    ret_stack #(.DATA_W(10), .DEPTH(16), .INC(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clr_err   (clr_err),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs, advance one edge, then sample just after it.
    task automatic cyc(input logic pu, input logic po, input logic [9:0] d, input logic ce);
        push      = pu;
        pop       = po;
        push_data = d;
        clr_err   = ce;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cyc(1'b0, 1'b0, 10'd0, 1'b0);
        cyc(1'b0, 1'b0, 10'd0, 1'b0);
        reset = 1'b0;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_pop_valid", pop_valid, 0);
        check_eq("rst_pop_data", pop_data, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_unf", underflow, 0);

        // push 5, 9, 12 then pop three times back-to-back
        cyc(1'b1, 1'b0, 10'd5, 1'b0);
        cyc(1'b1, 1'b0, 10'd9, 1'b0);
        cyc(1'b1, 1'b0, 10'd12, 1'b0);
        check_eq("push3_count", count, 3);
        check_eq("push3_top", top, 12);
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
        check_eq("pop1_data", pop_data, 13);
        check_eq("pop1_valid", pop_valid, 1);
        check_eq("pop1_count", count, 2);
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
        check_eq("pop2_data", pop_data, 10);
        check_eq("pop2_valid", pop_valid, 1);
        check_eq("pop2_count", count, 1);
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
        check_eq("pop3_data", pop_data, 6);
        check_eq("pop3_valid", pop_valid, 1);
        check_eq("pop3_count", count, 0);
        check_eq("pop3_empty", empty, 1);
        cyc(1'b0, 1'b0, 10'd0, 1'b0);
        check_eq("idle_valid", pop_valid, 0);
        check_eq("idle_hold", pop_data, 6);

        // pop while empty
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
        check_eq("unf_flag", underflow, 1);
        check_eq("unf_valid", pop_valid, 0);
        check_eq("unf_hold", pop_data, 6);
        check_eq("unf_count", count, 0);
        cyc(1'b0, 1'b0, 10'd0, 1'b1);
        check_eq("clr_unf", underflow, 0);

        // fill to DEPTH, then push while full
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 10'(i), 1'b0);
        end
        check_eq("fill_count", count, 16);
        check_eq("fill_full", full, 1);
        check_eq("fill_ovf", overflow, 0);
        cyc(1'b1, 1'b0, 10'd99, 1'b0);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_full", full, 1);
        check_eq("ovf_count", count, 16);
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
`ifdef RET_STACK_WRAP_EN
        check_eq("ovf_pop_data", pop_data, 100);
`else
        check_eq("ovf_pop_data", pop_data, 16);
`endif
        check_eq("ovf_pop_count", count, 15);

        reset = 1'b1;
        cyc(1'b0, 1'b0, 10'd0, 1'b0);
        reset = 1'b0;
        check_eq("rst2_count", count, 0);
        check_eq("rst2_ovf", overflow, 0);

        // simultaneous push+pop, non-empty then empty
        cyc(1'b1, 1'b0, 10'd7, 1'b0);
        check_eq("swap_pre_top", top, 7);
        cyc(1'b1, 1'b1, 10'd20, 1'b0);
        check_eq("swap_data", pop_data, 8);
        check_eq("swap_valid", pop_valid, 1);
        check_eq("swap_count", count, 1);
        check_eq("swap_top", top, 20);
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
        check_eq("swap_drain", pop_data, 21);
        check_eq("swap_drain_count", count, 0);
        cyc(1'b1, 1'b1, 10'd20, 1'b0);
        check_eq("eswap_unf", underflow, 1);
        check_eq("eswap_count", count, 1);
        check_eq("eswap_top", top, 20);
        check_eq("eswap_valid", pop_valid, 0);
        check_eq("eswap_hold", pop_data, 21);

        // increment wraps modulo 2^DATA_W
        cyc(1'b1, 1'b0, 10'd1023, 1'b0);
        check_eq("wrap_top", top, 1023);
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
        check_eq("wrap_data", pop_data, 0);
        check_eq("wrap_valid", pop_valid, 1);
        check_eq("wrap_count", count, 1);
        check_eq("wrap_top_after", top, 20);

        // reset mid-sequence with count 4 and pop asserted
        for (int i = 30; i < 34; i++) begin
            cyc(1'b1, 1'b0, 10'(i), 1'b0);
        end
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
        check_eq("pre_rst_data", pop_data, 34);
        check_eq("pre_rst_count", count, 4);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 10'd0, 1'b0);
        reset = 1'b0;
        check_eq("mrst_count", count, 0);
        check_eq("mrst_valid", pop_valid, 0);
        check_eq("mrst_data", pop_data, 0);
        check_eq("mrst_ovf", overflow, 0);
        check_eq("mrst_unf", underflow, 0);
        check_eq("mrst_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
